fc_argmax: RTL and testbench

Classification stage directly downstream of the pooling/fully-connected layer. On the rising edge of `fc_done` it captures the ten signed class scores `prob_0`..`prob_9`. It then scans them sequentially, one comparison per cycle, to find the maximum, and presents the winning class index and a saturated score under a valid/ack handshake.

---
 rtl/fc_argmax_if.sv | 12 +
 rtl/fc_argmax.sv | 129 ++++++++++++
 tb/tb_fc_argmax.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fc_argmax_if.sv
// rtl/fc_argmax_if.sv - result handshake bundle between fc_argmax and its consumer
interface fc_argmax_if #(
  parameter int SCORE_WIDTH = 32
);
  logic [3:0]                    class_id;
  logic signed [SCORE_WIDTH-1:0] class_score;
  logic                          result_valid;
  logic                          result_ack;

  modport master (output class_id, class_score, result_valid, input result_ack);
  modport slave  (input class_id, class_score, result_valid, output result_ack);
endinterface

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - captures ten class scores on fc_done rise, scans for the max one per cycle
module fc_argmax #(
  parameter int DATA_WIDTH  = 113,
  parameter int SCORE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fc_done,
  input  logic signed [DATA_WIDTH-1:0] prob_0,
  input  logic signed [DATA_WIDTH-1:0] prob_1,
  input  logic signed [DATA_WIDTH-1:0] prob_2,
  input  logic signed [DATA_WIDTH-1:0] prob_3,
  input  logic signed [DATA_WIDTH-1:0] prob_4,
  input  logic signed [DATA_WIDTH-1:0] prob_5,
  input  logic signed [DATA_WIDTH-1:0] prob_6,
  input  logic signed [DATA_WIDTH-1:0] prob_7,
  input  logic signed [DATA_WIDTH-1:0] prob_8,
  input  logic signed [DATA_WIDTH-1:0] prob_9,
  output logic                         busy,
  fc_argmax_if.master                  res
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH-SCORE_WIDTH+1){1'b0}}, {(SCORE_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    {{(DATA_WIDTH-SCORE_WIDTH+1){1'b1}}, {(SCORE_WIDTH-1){1'b0}}};

  state_t state, state_next;
  logic   fc_done_q;
  logic   start;
  logic [3:0] idx;
  logic [3:0] best_idx;
  logic signed [DATA_WIDTH-1:0] best_val;
  logic signed [DATA_WIDTH-1:0] score [10];

  logic signed [DATA_WIDTH-1:0]  cand;
  logic                          cand_gt;
  logic signed [DATA_WIDTH-1:0]  final_val;
  logic [3:0]                    final_idx;
  logic signed [SCORE_WIDTH-1:0] sat_val;

  assign start = fc_done & ~fc_done_q;

  // Strictly-greater keeps the earliest index on ties.
  always_comb begin
    cand      = score[idx];
    cand_gt   = cand > best_val;
    final_val = cand_gt ? cand : best_val;
    final_idx = cand_gt ? idx : best_idx;
    if (final_val > SAT_MAX)
      sat_val = SAT_MAX[SCORE_WIDTH-1:0];
    else if (final_val < SAT_MIN)
      sat_val = SAT_MIN[SCORE_WIDTH-1:0];
    else
      sat_val = final_val[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (idx == 4'd9) state_next = DONE;
      DONE:    if (res.result_ack && res.result_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_done_q        <= 1'b0;
      idx              <= 4'd0;
      best_val         <= '0;
      best_idx         <= 4'd0;
      res.class_id     <= 4'd0;
      res.class_score  <= '0;
      res.result_valid <= 1'b0;
    end else begin
      fc_done_q <= fc_done;
      case (state)
        IDLE: begin
          if (start) begin
            score[0] <= prob_0;
            score[1] <= prob_1;
            score[2] <= prob_2;
            score[3] <= prob_3;
            score[4] <= prob_4;
            score[5] <= prob_5;
            score[6] <= prob_6;
            score[7] <= prob_7;
            score[8] <= prob_8;
            score[9] <= prob_9;
            best_val <= prob_0;
            best_idx <= 4'd0;
            idx      <= 4'd1;
          end
        end
        SCAN: begin
          best_val <= final_val;
          best_idx <= final_idx;
          if (idx == 4'd9) begin
            idx              <= 4'd0;
            res.class_id     <= final_idx;
            res.class_score  <= sat_val;
            res.result_valid <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          if (res.result_ack && res.result_valid)
            res.result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - table-driven and randomized checks of fc_argmax against an argmax model
module tb_fc_argmax;
  localparam int DW = 113;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fc_done = 1'b0;
  logic busy;
  logic signed [DW-1:0] p [10];

  int n_cmp = 0;
  int n_fail = 0;

  fc_argmax_if #(.SCORE_WIDTH(SW)) bus ();

  fc_argmax #(.DATA_WIDTH(DW), .SCORE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .fc_done(fc_done),
    .prob_0(p[0]), .prob_1(p[1]), .prob_2(p[2]), .prob_3(p[3]), .prob_4(p[4]),
    .prob_5(p[5]), .prob_6(p[6]), .prob_7(p[7]), .prob_8(p[8]), .prob_9(p[9]),
    .busy(busy), .res(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0][DW-1:0] s;
    logic [3:0]         id;
    logic [SW-1:0]      score;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Argmax over the current inputs: first index wins ties, then clamp to SW bits.
  task automatic model(output logic [3:0] id, output logic [SW-1:0] sc);
    logic signed [DW-1:0] best, hi, lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    best = p[0];
    id = 4'd0;
    for (int k = 1; k < 10; k++)
      if (p[k] > best) begin best = p[k]; id = 4'(k); end
    if (best > hi)      sc = 32'h7FFFFFFF;
    else if (best < lo) sc = 32'h80000000;
    else                sc = best[SW-1:0];
  endtask

  function automatic logic signed [DW-1:0] rnd_score();
    logic [127:0] r;
    logic signed [DW-1:0] v;
    r = {$urandom, $urandom, $urandom, $urandom};
    v = r[DW-1:0];
    return v >>> $urandom_range(DW-1, 0);
  endfunction

  task automatic start_scan();
    fc_done = 1'b0;
    tick();
    fc_done = 1'b1;
    tick();
    chk("busy_after_capture", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_result(input string nm, input int exp_lat,
                             input logic [3:0] eid, input logic [SW-1:0] esc);
    int n;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus.result_valid) break;
    end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    chk({nm, "_class_id"}, {60'd0, bus.class_id}, {60'd0, eid});
    chk({nm, "_class_score"}, {32'd0, bus.class_score}, {32'd0, esc});
  endtask

  task automatic do_ack(input string nm);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    chk({nm, "_valid_after_ack"}, {63'd0, bus.result_valid}, 64'd0);
    chk({nm, "_busy_after_ack"}, {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs [5];
  logic [3:0]    eid;
  logic [SW-1:0] esc;
  logic [3:0]    hold_id;
  logic [SW-1:0] hold_sc;
  int            seen;

  initial begin
    logic [DW-1:0] big;
    for (int k = 0; k < 10; k++) vecs[0].s[k] = DW'(k * 100);
    vecs[0].s[6] = DW'(5000);
    vecs[0].id = 4'd6; vecs[0].score = 32'd5000;
    for (int k = 0; k < 10; k++) vecs[1].s[k] = -DW'(100);
    vecs[1].s[3] = -DW'(7); vecs[1].s[8] = -DW'(7);
    vecs[1].id = 4'd3; vecs[1].score = 32'hFFFFFFF9;
    for (int k = 0; k < 10; k++) vecs[2].s[k] = -DW'(1);
    vecs[2].id = 4'd0; vecs[2].score = 32'hFFFFFFFF;
    big = '0; big[40] = 1'b1;
    for (int k = 0; k < 10; k++) vecs[3].s[k] = '0;
    vecs[3].s[2] = big;
    vecs[3].id = 4'd2; vecs[3].score = 32'h7FFFFFFF;
    big = '0; big[50] = 1'b1;
    for (int k = 0; k < 10; k++) vecs[4].s[k] = -big;
    vecs[4].id = 4'd0; vecs[4].score = 32'h80000000;

    bus.result_ack = 1'b0;
    for (int k = 0; k < 10; k++) p[k] = '0;
    tick(); tick();
    chk("reset_class_id", {60'd0, bus.class_id}, 64'd0);
    chk("reset_class_score", {32'd0, bus.class_score}, 64'd0);
    chk("reset_valid", {63'd0, bus.result_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 10; k++) p[k] = $signed(vecs[v].s[k]);
      start_scan();
      wait_result($sformatf("vec%0d", v), 9, vecs[v].id, vecs[v].score);
      do_ack($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_id_kept", v), {60'd0, bus.class_id}, {60'd0, vecs[v].id});
      chk($sformatf("vec%0d_score_kept", v), {32'd0, bus.class_score}, {32'd0, vecs[v].score});
    end

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 10; k++) p[k] = rnd_score();
      if ($urandom_range(3, 0) == 0) p[$urandom_range(9, 0)] = p[$urandom_range(9, 0)];
      model(eid, esc);
      start_scan();
      wait_result($sformatf("rand%0d", t), 9, eid, esc);
      do_ack($sformatf("rand%0d", t));
    end

    // Backpressure, then level-held fc_done must not retrigger.
    for (int k = 0; k < 10; k++) p[k] = DW'(k * 3);
    model(eid, esc);
    start_scan();
    wait_result("bp", 9, eid, esc);
    hold_id = bus.class_id;
    hold_sc = bus.class_score;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_hold", {27'd0, bus.result_valid, hold_id, hold_sc},
          {27'd0, 1'b1, eid, esc});
    end
    do_ack("bp");
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.result_valid || busy) seen++;
    end
    chk("no_retrigger", 64'(seen), 64'd0);
    for (int k = 0; k < 10; k++) p[k] = -DW'(k * 11);
    model(eid, esc);
    start_scan();
    wait_result("refire", 9, eid, esc);
    do_ack("refire");

    // Ack held from capture: ignored while scanning, accepted one cycle after valid rises.
    for (int k = 0; k < 10; k++) p[k] = DW'(50 - k);
    start_scan();
    bus.result_ack = 1'b1;
    wait_result("early_ack", 9, 4'd0, 32'd50);
    tick();
    chk("early_ack_cleared", {63'd0, bus.result_valid}, 64'd0);
    bus.result_ack = 1'b0;

    // Inputs changing after capture do not affect the result.
    for (int k = 0; k < 10; k++) p[k] = DW'(k * 10);
    p[4] = DW'(777);
    start_scan();
    tick();
    p[4] = {1'b1, {(DW-1){1'b0}}};
    wait_result("late_change", 8, 4'd4, 32'd777);
    do_ack("late_change");

    // Reset at E5 with fc_done still high, then automatic restart.
    for (int k = 0; k < 10; k++) p[k] = DW'(k + 1000);
    start_scan();
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_class_id", {60'd0, bus.class_id}, 64'd0);
    chk("midrst_class_score", {32'd0, bus.class_score}, 64'd0);
    chk("midrst_valid", {63'd0, bus.result_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("midrst_restart_busy", {63'd0, busy}, 64'd1);
    wait_result("midrst", 9, 4'd9, 32'd1009);
    do_ack("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
